// File: rtl/pe_bist_ctrl.sv
`default_nettype none
// pe_bist_ctrl: LFSR-driven built-in self test for a 4-function PE (add, sub, mul, unsigned gt).
// Define PE_BIST_TIMEOUT_EN to fail a vector whose result does not arrive within TIMEOUT WAIT cycles.
module pe_bist_ctrl #(
    parameter int          dataLen = 32,
    parameter int          ITER    = 16,
    parameter logic [31:0] SEED    = 32'hACE1_0001,
    parameter int          TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [1:0]         fn,
    output logic [dataLen-1:0] op_a,
    output logic [dataLen-1:0] op_b,
    output logic               op_valid,
    input  logic [dataLen-1:0] res,
    input  logic               res_valid,
    output logic               busy,
    output logic               done,
    output logic               fail_flag,
    output logic [1:0]         fail_fn,
    output logic [15:0]        fail_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [31:0] c_TAPS       = 32'h8020_0003;
    localparam logic [15:0] c_LAST_IDX   = 16'(ITER - 1);
    localparam logic [2:0]  c_RAND_PHASE = 3'd4;

    state_t             state_q;
    logic [31:0]        lfsr_q;
    logic [15:0]        idx_q;
    logic [2:0]         phase_q;
    logic [dataLen-1:0] res_q;
    logic [dataLen-1:0] op_a_q;
    logic [dataLen-1:0] op_b_q;
    logic [1:0]         fn_q;
    logic [1:0]         fail_fn_q;
    logic [15:0]        fail_idx_q;
    logic               op_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;

`ifdef PE_BIST_TIMEOUT_EN
    localparam int          c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    logic [c_TW-1:0] wcnt_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? c_TAPS : 32'h0);
    endfunction

    logic [31:0]        w_src;
    logic [31:0]        w_s1;
    logic [31:0]        w_s2;
    logic [2:0]         w_phase_nxt;
    logic [1:0]         w_fn_load;
    logic [dataLen-1:0] w_gold;
    logic               w_last_vec;
    logic               w_load;

    always_comb begin
        w_last_vec = (idx_q == c_LAST_IDX);
        // A fresh run always restarts the operand stream from SEED.
        w_src      = (state_q == IDLE) ? SEED : lfsr_q;
        w_s1       = lfsr_step(w_src);
        w_s2       = lfsr_step(w_s1);
        if (state_q == IDLE)
            w_phase_nxt = 3'd0;
        else if (w_last_vec)
            w_phase_nxt = phase_q + 3'd1;
        else
            w_phase_nxt = phase_q;
        w_fn_load = (w_phase_nxt == c_RAND_PHASE) ? w_src[1:0] : w_phase_nxt[1:0];
        w_load    = ((state_q == IDLE) && start) ||
                    ((state_q == NEXT) && !(w_last_vec && (phase_q == c_RAND_PHASE)));
        w_gold    = '0;
        case (fn_q)
            2'd0:    w_gold = op_a_q + op_b_q;
            2'd1:    w_gold = op_a_q - op_b_q;
            2'd2:    w_gold = op_a_q * op_b_q;
            default: w_gold[0] = (op_a_q > op_b_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            idx_q      <= '0;
            phase_q    <= '0;
            res_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            fn_q       <= '0;
            fail_fn_q  <= '0;
            fail_idx_q <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef PE_BIST_TIMEOUT_EN
            wcnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) busy_q <= 1'b1;
                ISSUE: begin
                    op_valid_q <= 1'b0;
                    state_q    <= WAIT;
`ifdef PE_BIST_TIMEOUT_EN
                    wcnt_q     <= '0;
`endif
                end
                WAIT: begin
                    if (res_valid) begin
                        res_q   <= res;
                        state_q <= CHECK;
                    end
`ifdef PE_BIST_TIMEOUT_EN
                    else if (wcnt_q == c_TMO_LAST) begin
                        fail_q     <= 1'b1;
                        fail_fn_q  <= fn_q;
                        fail_idx_q <= idx_q;
                        busy_q     <= 1'b0;
                        state_q    <= FAIL;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
`endif
                end
                CHECK: begin
                    if (res_q != w_gold) begin
                        fail_q     <= 1'b1;
                        fail_fn_q  <= fn_q;
                        fail_idx_q <= idx_q;
                        busy_q     <= 1'b0;
                        state_q    <= FAIL;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (w_last_vec && (phase_q == c_RAND_PHASE)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                FAIL: begin
                    if (start) begin
                        fail_q     <= 1'b0;
                        fail_fn_q  <= '0;
                        fail_idx_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Shared vector launch from IDLE (first vector) and NEXT (every later vector).
            if (w_load) begin
                phase_q    <= w_phase_nxt;
                idx_q      <= ((state_q == IDLE) || w_last_vec) ? 16'd0 : idx_q + 16'd1;
                fn_q       <= w_fn_load;
                op_a_q     <= dataLen'(w_src);
                op_b_q     <= dataLen'(w_s1);
                lfsr_q     <= w_s2;
                op_valid_q <= 1'b1;
                state_q    <= ISSUE;
            end
        end
    end

    assign fn        = fn_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail_flag = fail_q;
    assign fail_fn   = fail_fn_q;
    assign fail_idx  = fail_idx_q;

endmodule
`default_nettype wire
